// File: rtl/trng_byte_conditioner.sv
// Raw ring-oscillator bit stream -> health tests (RCT/APT) -> von Neumann
// corrector -> byte packer -> one-cycle trng_valid/trng_byte pulses.
module trng_byte_conditioner #(
  parameter int RCT_CUTOFF    = 32,
  parameter int APT_WINDOW    = 512,
  parameter int APT_CUTOFF    = 410,
  parameter int STARTUP_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       raw_bit,
  input  logic       raw_valid,
  input  logic       clear_fail,
  output logic [7:0] trng_byte,
  output logic       trng_valid,
  output logic       health_fail,
  output logic       startup_done
);

  localparam int RCT_W     = $clog2(RCT_CUTOFF) + 1;
  localparam int APT_POS_W = $clog2(APT_WINDOW) + 1;
  localparam int APT_CNT_W = $clog2(APT_CUTOFF) + 1;
  localparam int START_W   = $clog2(STARTUP_BYTES) + 1;
  localparam int BIT_W     = 4;

  localparam logic [RCT_W-1:0]     RCT_LIMIT   = RCT_W'(RCT_CUTOFF);
  localparam logic [RCT_W-1:0]     RCT_ONE     = RCT_W'(1);
  localparam logic [APT_POS_W-1:0] APT_LAST    = APT_POS_W'(APT_WINDOW);
  localparam logic [APT_POS_W-1:0] APT_POS_ONE = APT_POS_W'(1);
  localparam logic [APT_CNT_W-1:0] APT_LIMIT   = APT_CNT_W'(APT_CUTOFF);
  localparam logic [APT_CNT_W-1:0] APT_CNT_ONE = APT_CNT_W'(1);
  localparam logic [START_W-1:0]   START_LIMIT = START_W'(STARTUP_BYTES);
  localparam logic [START_W-1:0]   START_ONE   = START_W'(1);
  localparam logic [BIT_W-1:0]     BIT_LAST    = BIT_W'(7);
  localparam logic [BIT_W-1:0]     BIT_ONE     = BIT_W'(1);
  localparam logic                 START_DONE_INIT = (STARTUP_BYTES == 0);

  // Health-test state
  logic [RCT_W-1:0]     rct_cnt_r, rct_cnt_s;
  logic                 rct_bit_r, rct_bit_s;
  logic                 rct_trip_s;
  logic [APT_POS_W-1:0] apt_pos_r, apt_pos_s;
  logic [APT_CNT_W-1:0] apt_cnt_r, apt_cnt_s;
  logic                 apt_ref_r, apt_ref_s;
  logic                 apt_trip_s;

  // Corrector, packer, startup and output state
  logic                 pair_have_r, pair_have_s;
  logic                 pair_first_r, pair_first_s;
  logic [7:0]           shift_r, shift_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [START_W-1:0]   start_cnt_r, start_cnt_s;
  logic                 startup_done_r, startup_done_s;
  logic                 health_fail_r, health_fail_s;
  logic [7:0]           trng_byte_r, trng_byte_s;
  logic                 trng_valid_r, trng_valid_s;
  logic                 fail_s;
  logic [7:0]           done_byte_s;

  // Repetition count and adaptive proportion tests on every accepted raw bit.
  always_comb begin
    rct_cnt_s  = rct_cnt_r;
    rct_bit_s  = rct_bit_r;
    rct_trip_s = 1'b0;
    apt_pos_s  = apt_pos_r;
    apt_cnt_s  = apt_cnt_r;
    apt_ref_s  = apt_ref_r;
    apt_trip_s = 1'b0;
    if (clear_fail || !enable) begin
      rct_cnt_s = '0;
      apt_pos_s = '0;
      apt_cnt_s = '0;
    end else if (raw_valid) begin
      rct_bit_s = raw_bit;
      if ((rct_cnt_r != '0) && (raw_bit == rct_bit_r)) begin
        if (rct_cnt_r != RCT_LIMIT) begin
          rct_cnt_s = rct_cnt_r + RCT_ONE;
        end else begin
          rct_cnt_s = rct_cnt_r;
        end
      end else begin
        rct_cnt_s = RCT_ONE;
      end
      rct_trip_s = (rct_cnt_s == RCT_LIMIT);

      // A zero position means no window is open yet (after reset/clear/disable).
      if ((apt_pos_r == '0) || (apt_pos_r == APT_LAST)) begin
        apt_ref_s = raw_bit;
        apt_pos_s = APT_POS_ONE;
        apt_cnt_s = APT_CNT_ONE;
      end else begin
        apt_pos_s = apt_pos_r + APT_POS_ONE;
        if ((raw_bit == apt_ref_r) && (apt_cnt_r != APT_LIMIT)) begin
          apt_cnt_s = apt_cnt_r + APT_CNT_ONE;
        end else begin
          apt_cnt_s = apt_cnt_r;
        end
      end
      apt_trip_s = (apt_cnt_s == APT_LIMIT);
    end else begin
      rct_trip_s = 1'b0;
      apt_trip_s = 1'b0;
    end
  end

  // Von Neumann pairing, byte packing, startup discard and output pulse.
  always_comb begin
    fail_s         = health_fail_r | rct_trip_s | apt_trip_s;
    pair_have_s    = pair_have_r;
    pair_first_s   = pair_first_r;
    shift_s        = shift_r;
    bit_cnt_s      = bit_cnt_r;
    start_cnt_s    = start_cnt_r;
    startup_done_s = startup_done_r;
    health_fail_s  = health_fail_r;
    trng_byte_s    = trng_byte_r;
    trng_valid_s   = 1'b0;
    done_byte_s    = {shift_r[6:0], pair_first_r};
    if (clear_fail) begin
      pair_have_s    = 1'b0;
      pair_first_s   = 1'b0;
      shift_s        = 8'h00;
      bit_cnt_s      = '0;
      start_cnt_s    = '0;
      startup_done_s = START_DONE_INIT;
      health_fail_s  = 1'b0;
    end else if (!enable) begin
      pair_have_s  = 1'b0;
      pair_first_s = 1'b0;
      shift_s      = 8'h00;
      bit_cnt_s    = '0;
    end else if (fail_s) begin
      // A byte completing on the failing edge is dropped with the rest.
      pair_have_s   = 1'b0;
      pair_first_s  = 1'b0;
      shift_s       = 8'h00;
      bit_cnt_s     = '0;
      health_fail_s = 1'b1;
    end else if (raw_valid) begin
      if (!pair_have_r) begin
        pair_have_s  = 1'b1;
        pair_first_s = raw_bit;
      end else begin
        pair_have_s  = 1'b0;
        pair_first_s = 1'b0;
        // 01 -> 0 and 10 -> 1: the corrected bit equals the first of the pair.
        if (pair_first_r != raw_bit) begin
          if (bit_cnt_r == BIT_LAST) begin
            shift_s   = 8'h00;
            bit_cnt_s = '0;
            if (start_cnt_r != START_LIMIT) begin
              start_cnt_s = start_cnt_r + START_ONE;
              if ((start_cnt_r + START_ONE) == START_LIMIT) begin
                startup_done_s = 1'b1;
              end else begin
                startup_done_s = startup_done_r;
              end
            end else begin
              trng_byte_s  = done_byte_s;
              trng_valid_s = 1'b1;
            end
          end else begin
            shift_s   = done_byte_s;
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          shift_s   = shift_r;
          bit_cnt_s = bit_cnt_r;
        end
      end
    end else begin
      trng_valid_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rct_cnt_r      <= '0;
      rct_bit_r      <= 1'b0;
      apt_pos_r      <= '0;
      apt_cnt_r      <= '0;
      apt_ref_r      <= 1'b0;
      pair_have_r    <= 1'b0;
      pair_first_r   <= 1'b0;
      shift_r        <= 8'h00;
      bit_cnt_r      <= '0;
      start_cnt_r    <= '0;
      startup_done_r <= START_DONE_INIT;
      health_fail_r  <= 1'b0;
      trng_byte_r    <= 8'h00;
      trng_valid_r   <= 1'b0;
    end else begin
      rct_cnt_r      <= rct_cnt_s;
      rct_bit_r      <= rct_bit_s;
      apt_pos_r      <= apt_pos_s;
      apt_cnt_r      <= apt_cnt_s;
      apt_ref_r      <= apt_ref_s;
      pair_have_r    <= pair_have_s;
      pair_first_r   <= pair_first_s;
      shift_r        <= shift_s;
      bit_cnt_r      <= bit_cnt_s;
      start_cnt_r    <= start_cnt_s;
      startup_done_r <= startup_done_s;
      health_fail_r  <= health_fail_s;
      trng_byte_r    <= trng_byte_s;
      trng_valid_r   <= trng_valid_s;
    end
  end

  assign trng_byte    = trng_byte_r;
  assign trng_valid   = trng_valid_r;
  assign health_fail  = health_fail_r;
  assign startup_done = startup_done_r;

endmodule

// File: tb/tb_trng_byte_conditioner.sv
// Directed bench: one instance without startup discard, one with defaults,
// both driven by the same raw stream.
module tb_trng_byte_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       raw_bit = 1'b0;
  logic       raw_valid = 1'b0;
  logic       clear_fail = 1'b0;
  logic [7:0] byte0, byte1;
  logic       valid0, valid1, hf0, hf1, sd0, sd1;

  int checks = 0;
  int errors = 0;
  int cnt0 = 0, cnt1 = 0;
  logic [7:0] last0 = 8'h00, last1 = 8'h00;
  int base0, base1;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          exp_pulses;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  trng_byte_conditioner #(.STARTUP_BYTES(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .raw_bit(raw_bit),
    .raw_valid(raw_valid), .clear_fail(clear_fail), .trng_byte(byte0),
    .trng_valid(valid0), .health_fail(hf0), .startup_done(sd0)
  );

  trng_byte_conditioner dut1 (
    .clk(clk), .rst(rst), .enable(enable), .raw_bit(raw_bit),
    .raw_valid(raw_valid), .clear_fail(clear_fail), .trng_byte(byte1),
    .trng_valid(valid1), .health_fail(hf1), .startup_done(sd1)
  );

  // Count output pulses and remember the last emitted byte of each instance.
  always @(negedge clk) begin
    if (valid0) begin
      cnt0  <= cnt0 + 1;
      last0 <= byte0;
    end
    if (valid1) begin
      cnt1  <= cnt1 + 1;
      last1 <= byte1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic b);
    @(negedge clk);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) drive(bits[k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      raw_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // The raw bit offered during clear_fail must be ignored.
  task automatic do_clear();
    @(negedge clk);
    clear_fail = 1'b1;
    raw_bit    = 1'b1;
    raw_valid  = 1'b1;
    @(posedge clk);
    #1;
    clear_fail = 1'b0;
    raw_valid  = 1'b0;
  endtask

  task automatic pulse_disable();
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'h0000_695A, 16, 1, 8'h63};
    vecs[1] = '{32'h004A_D46E, 24, 1, 8'h63};
    vecs[2] = '{32'h0000_AAAA, 16, 1, 8'hFF};
    vecs[3] = '{32'h0000_5555, 16, 1, 8'h00};
    vecs[4] = '{32'h0000_34AD, 15, 0, 8'h00};
    vecs[5] = '{32'h695A_AAAA, 32, 2, 8'hFF};
    vecs[6] = '{32'h0000_9966, 16, 1, 8'hA5};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte", byte0, 8'h00);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_hf", hf0, 1'b0);
    chk("rst_sd_nostartup", sd0, 1'b1);
    chk("rst_sd_default", sd1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_clear();
      base0 = cnt0;
      base1 = cnt1;
      send(vecs[i].bits, vecs[i].nbits);
      chk($sformatf("vec%0d_latency", i), valid0, (vecs[i].exp_pulses != 0));
      idle(2);
      chk($sformatf("vec%0d_pulses", i), cnt0 - base0, vecs[i].exp_pulses);
      chk($sformatf("vec%0d_startup_drop", i), cnt1 - base1, 0);
      chk($sformatf("vec%0d_hf", i), hf0, 1'b0);
      if (vecs[i].exp_pulses != 0) begin
        chk($sformatf("vec%0d_byte", i), last0, vecs[i].exp_byte);
        chk($sformatf("vec%0d_hold", i), byte0, vecs[i].exp_byte);
      end
    end

    // Startup discard: only the fifth byte of the default instance is output.
    do_clear();
    chk("clear_sd", sd1, 1'b0);
    base0 = cnt0;
    base1 = cnt1;
    for (int b = 1; b <= 5; b++) begin
      send(32'h0000_695A, 16);
      if (b == 3) chk("startup_sd_b3", sd1, 1'b0);
      if (b == 4) begin
        chk("startup_sd_b4", sd1, 1'b1);
        chk("startup_valid_b4", valid1, 1'b0);
        chk("startup_cnt_b4", cnt1 - base1, 0);
      end
      if (b == 5) chk("startup_valid_b5", valid1, 1'b1);
    end
    idle(2);
    chk("startup_pulses", cnt1 - base1, 1);
    chk("startup_byte", last1, 8'h63);
    chk("startup_ref_pulses", cnt0 - base0, 5);

    // Repetition count test.
    do_clear();
    for (int k = 0; k < 31; k++) drive(1'b1);
    chk("rct_31", hf0, 1'b0);
    drive(1'b1);
    chk("rct_32_a", hf0, 1'b1);
    chk("rct_32_b", hf1, 1'b1);
    base0 = cnt0;
    send(32'h0000_695A, 16);
    idle(2);
    chk("fail_suppress", cnt0 - base0, 0);
    chk("fail_sticky", hf0, 1'b1);
    do_clear();
    chk("clear_hf", hf0, 1'b0);
    chk("clear_sd_after_fail", sd1, 1'b0);
    base0 = cnt0;
    send(32'h0000_695A, 16);
    idle(2);
    chk("after_clear_pulses", cnt0 - base0, 1);
    chk("after_clear_byte", last0, 8'h63);

    // Adaptive proportion test: 11110 trips at bit 512.
    do_clear();
    for (int k = 1; k <= 512; k++) begin
      drive(((k - 1) % 5) != 4);
      if (k == 511) chk("apt_511", hf0, 1'b0);
    end
    chk("apt_512", hf0, 1'b1);
    // 1110 gives 384 per window; two windows must not accumulate.
    do_clear();
    for (int k = 1; k <= 1024; k++) drive(((k - 1) % 4) != 3);
    chk("apt_1110", hf0, 1'b0);

    // enable=0 flushes a partial pair/byte and the RCT run.
    do_clear();
    send(32'h0000_695A >> 7, 9);
    pulse_disable();
    base0 = cnt0;
    send(32'h0000_695A, 16);
    idle(2);
    chk("disable_pulses", cnt0 - base0, 1);
    chk("disable_byte", last0, 8'h63);
    for (int k = 0; k < 20; k++) drive(1'b1);
    pulse_disable();
    for (int k = 0; k < 20; k++) drive(1'b1);
    chk("disable_rct", hf0, 1'b0);

    // Asynchronous reset in the middle of a byte.
    do_clear();
    send(32'h0000_695A >> 6, 10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_byte", byte0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    base0 = cnt0;
    send(32'h0000_695A, 16);
    idle(2);
    chk("midrst_pulses", cnt0 - base0, 1);
    chk("midrst_byte", last0, 8'h63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
